// File: rtl/smem_pkg.sv
// Shared definitions for the backward-pass token path.
// Contents:
//   status_e   - one-hot stage status. All zeros means BUBBLE (no real work).
//   READ_NUM_W - default read-number width.
//   PAYLOAD_W  - default width of the opaque k/l/cnt/p_x payload.
//   token_t    - token bundle at the default widths.
//   is_bubble  - true when a status vector carries no stage bit.
package smem_pkg;

    localparam int READ_NUM_W = 9;
    localparam int PAYLOAD_W  = 1024;
    localparam int STATUS_W   = 6;

    typedef enum logic [STATUS_W-1:0] {
        BUBBLE  = 6'b000000,
        F_INIT  = 6'b000001,
        F_RUN   = 6'b000010,
        F_BREAK = 6'b000100,
        BCK_INI = 6'b001000,
        BCK_RUN = 6'b010000,
        BCK_END = 6'b100000
    } status_e;

    typedef struct packed {
        logic [STATUS_W-1:0]   status;
        logic [READ_NUM_W-1:0] read_num;
        logic [PAYLOAD_W-1:0]  payload;
    } token_t;

    function automatic logic is_bubble(input logic [STATUS_W-1:0] status);
        return status == BUBBLE;
    endfunction

endpackage

// File: rtl/bwd_ingress_pipe_if.sv
// Valid/ready token channel: status, read number and payload.
// Signals:
//   valid    - producer has a token
//   ready    - consumer takes the token on this edge
//   status   - one-hot stage status (0 = bubble)
//   read_num - read number
//   payload  - opaque token data
// Modports:
//   master - producer side (drives valid and the fields, samples ready)
//   slave  - consumer side (samples valid and the fields, drives ready)
interface bwd_ingress_pipe_if #(
    parameter int READ_NUM_W = 9,
    parameter int PAYLOAD_W  = 1024
);
    logic                  valid;
    logic                  ready;
    logic [5:0]            status;
    logic [READ_NUM_W-1:0] read_num;
    logic [PAYLOAD_W-1:0]  payload;

    modport master (output valid, status, read_num, payload, input ready);
    modport slave  (input valid, status, read_num, payload, output ready);
endinterface

// File: rtl/bwd_skid_fifo2.sv
// Two-entry skid FIFO at the pipe entrance.
// push_if.ready comes straight from a registered full flag, so the upstream
// ready never depends combinationally on anything downstream.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   flush     - empties the FIFO
//   push_if   - slave side: token written when valid && ready
//   head_if   - master side: valid while non-empty; ready pops the head
//   count     - tokens held (0..2)
module bwd_skid_fifo2
    import smem_pkg::*;
#(
    parameter int TOK_RN_W = 9,
    parameter int TOK_PL_W = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    bwd_ingress_pipe_if.slave  push_if,
    bwd_ingress_pipe_if.master head_if,
    output logic [1:0]        count
);

    logic [1:0]          count_reg;
    logic [1:0]          count_next;
    logic                full_reg;
    logic                push;
    logic                pop;
    logic                wr_idx;

    // Entry 0 is always the head; a pop shifts entry 1 down.
    logic [5:0]          status_reg   [2];
    logic [TOK_RN_W-1:0] read_num_reg [2];
    logic [TOK_PL_W-1:0] payload_reg  [2];

    assign push_if.ready = !full_reg;
    assign push          = push_if.valid && !full_reg;
    assign pop           = head_if.ready && (count_reg != 2'd0);

    assign head_if.valid    = (count_reg != 2'd0);
    assign head_if.status   = status_reg[0];
    assign head_if.read_num = read_num_reg[0];
    assign head_if.payload  = payload_reg[0];
    assign count            = count_reg;

    // Write slot after accounting for a same-edge pop: count 1 with a pop
    // refills the head, count 1 without a pop fills entry 1.
    assign wr_idx = count_reg[0] & ~pop;

    always_comb begin
        count_next = count_reg + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_reg <= 2'd0;
            full_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            full_reg  <= (count_next == 2'd2);
        end
    end

    // Storage carries no reset: validity lives entirely in count_reg.
    always_ff @(posedge clk) begin
        if (pop) begin
            status_reg[0]   <= status_reg[1];
            read_num_reg[0] <= read_num_reg[1];
            payload_reg[0]  <= payload_reg[1];
        end
        if (push) begin
            status_reg[wr_idx]   <= push_if.status;
            read_num_reg[wr_idx] <= push_if.read_num;
            payload_reg[wr_idx]  <= push_if.payload;
        end
    end

endmodule

// File: rtl/bwd_ingress_pipe.sv
// Ingress retiming pipe for backward-pass tokens.
// Tokens enter a 2-entry skid FIFO, then flow through DEPTH retiming stages
// that squeeze out empty slots. Bubble-status tokens may be dropped at entry.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   flush                         - discards every in-flight token
//   in_valid/in_ready             - upstream handshake
//   in_status/in_read_num/in_payload - upstream token fields
//   out_valid/out_ready           - downstream handshake
//   out_status/out_read_num/out_payload - last-stage token fields
//   occupancy                     - skid entries plus valid stages
//   bubble_drops                  - saturating count of dropped bubbles
module bwd_ingress_pipe #(
    parameter int DEPTH       = 1,
    parameter int PAYLOAD_W   = 1024,
    parameter int READ_NUM_W  = smem_pkg::READ_NUM_W,
    parameter int DROP_BUBBLE = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [5:0]                   in_status,
    input  logic [READ_NUM_W-1:0]        in_read_num,
    input  logic [PAYLOAD_W-1:0]         in_payload,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [5:0]                   out_status,
    output logic [READ_NUM_W-1:0]        out_read_num,
    output logic [PAYLOAD_W-1:0]         out_payload,
    output logic [$clog2(DEPTH+3)-1:0]   occupancy,
    output logic [15:0]                  bubble_drops
);

    localparam int OCC_W = $clog2(DEPTH + 3);

    logic                  accept;
    logic                  drop;
    logic [1:0]            skid_count;
    logic [15:0]           bubble_drops_reg;
    logic [OCC_W-1:0]      occ_sum;

    logic [DEPTH-1:0]      stage_valid;
    logic [DEPTH-1:0]      stage_free;
    logic [DEPTH-1:0]      stage_adv;
    logic [DEPTH-1:0]      stage_load;
    logic [5:0]            stage_status   [DEPTH];
    logic [READ_NUM_W-1:0] stage_read_num [DEPTH];
    logic [PAYLOAD_W-1:0]  stage_payload  [DEPTH];

    bwd_ingress_pipe_if #(.READ_NUM_W(READ_NUM_W), .PAYLOAD_W(PAYLOAD_W)) skid_in_if ();
    bwd_ingress_pipe_if #(.READ_NUM_W(READ_NUM_W), .PAYLOAD_W(PAYLOAD_W)) skid_head_if ();

    // Entry side: ready depends only on reset, flush and the registered
    // full flag, never on out_ready.
    assign in_ready = !rst && !flush && skid_in_if.ready;
    assign accept   = in_valid && in_ready;
    assign drop     = accept && (DROP_BUBBLE != 0) && smem_pkg::is_bubble(in_status);

    assign skid_in_if.valid    = accept && !drop;
    assign skid_in_if.status   = in_status;
    assign skid_in_if.read_num = in_read_num;
    assign skid_in_if.payload  = in_payload;
    assign skid_head_if.ready  = stage_load[0];

    bwd_skid_fifo2 #(
        .TOK_RN_W (READ_NUM_W),
        .TOK_PL_W (PAYLOAD_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push_if (skid_in_if),
        .head_if (skid_head_if),
        .count   (skid_count)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic                  valid_reg;
            logic [5:0]            status_reg;
            logic [READ_NUM_W-1:0] read_num_reg;
            logic [PAYLOAD_W-1:0]  payload_reg;
            logic [5:0]            src_status;
            logic [READ_NUM_W-1:0] src_read_num;
            logic [PAYLOAD_W-1:0]  src_payload;

            // A stage can take a token if it, or any stage ahead of it, is
            // empty, or the output is draining. Written in closed form so the
            // free flags depend on registers and out_ready only.
            assign stage_free[gi] = out_ready || !(&stage_valid[DEPTH-1:gi]);

            if (gi == 0) begin : g_head
                assign stage_load[gi] = skid_head_if.valid && stage_free[gi];
                assign src_status     = skid_head_if.status;
                assign src_read_num   = skid_head_if.read_num;
                assign src_payload    = skid_head_if.payload;
            end else begin : g_chain
                assign stage_load[gi] = stage_adv[gi-1];
                assign src_status     = stage_status[gi-1];
                assign src_read_num   = stage_read_num[gi-1];
                assign src_payload    = stage_payload[gi-1];
            end

            if (gi == DEPTH - 1) begin : g_last
                assign stage_adv[gi] = valid_reg && out_ready;
            end else begin : g_mid
                assign stage_adv[gi] = valid_reg && stage_free[gi+1];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg    <= 1'b0;
                    status_reg   <= smem_pkg::BUBBLE;
                    read_num_reg <= '0;
                    payload_reg  <= '0;
                end else begin
                    valid_reg <= !flush && (stage_load[gi] || (valid_reg && !stage_adv[gi]));
                    if (stage_load[gi] && !flush) begin
                        status_reg   <= src_status;
                        read_num_reg <= src_read_num;
                        payload_reg  <= src_payload;
                    end
                end
            end

            assign stage_valid[gi]    = valid_reg;
            assign stage_status[gi]   = status_reg;
            assign stage_read_num[gi] = read_num_reg;
            assign stage_payload[gi]  = payload_reg;
        end
    endgenerate

    assign out_valid    = stage_valid[DEPTH-1];
    assign out_status   = stage_status[DEPTH-1];
    assign out_read_num = stage_read_num[DEPTH-1];
    assign out_payload  = stage_payload[DEPTH-1];

    always_comb begin
        occ_sum = OCC_W'(skid_count);
        for (int i = 0; i < DEPTH; i++) begin
            occ_sum = occ_sum + OCC_W'(stage_valid[i]);
        end
    end
    assign occupancy = occ_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_drops_reg <= 16'd0;
        end else if (drop && (bubble_drops_reg != 16'hFFFF)) begin
            bubble_drops_reg <= bubble_drops_reg + 16'd1;
        end
    end
    assign bubble_drops = bubble_drops_reg;

endmodule

// File: tb/tb_bwd_ingress_pipe.sv
// Directed bench for bwd_ingress_pipe. Two instances share the input side:
//   dut_a: DEPTH=2, DROP_BUBBLE=1
//   dut_b: DEPTH=3, DROP_BUBBLE=0
// Each scenario checks the instance it targets; the other is ignored.
module tb_bwd_ingress_pipe;
    import smem_pkg::*;

    localparam int RN_W = 9;
    localparam int PL_W = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_ready_b;
    logic [2:0]  occ_a;
    logic [2:0]  occ_b;
    logic [15:0] drops_a;
    logic [15:0] drops_b;
    int          checks = 0;
    int          errors = 0;

    bwd_ingress_pipe_if #(.READ_NUM_W(RN_W), .PAYLOAD_W(PL_W)) up_if ();
    bwd_ingress_pipe_if #(.READ_NUM_W(RN_W), .PAYLOAD_W(PL_W)) a_out ();
    bwd_ingress_pipe_if #(.READ_NUM_W(RN_W), .PAYLOAD_W(PL_W)) b_out ();

    always #5 clk = ~clk;
    assign b_out.ready = a_out.ready;

    bwd_ingress_pipe #(.DEPTH(2), .PAYLOAD_W(PL_W), .READ_NUM_W(RN_W), .DROP_BUBBLE(1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(up_if.valid), .in_ready(up_if.ready), .in_status(up_if.status),
        .in_read_num(up_if.read_num), .in_payload(up_if.payload),
        .out_valid(a_out.valid), .out_ready(a_out.ready), .out_status(a_out.status),
        .out_read_num(a_out.read_num), .out_payload(a_out.payload),
        .occupancy(occ_a), .bubble_drops(drops_a)
    );

    bwd_ingress_pipe #(.DEPTH(3), .PAYLOAD_W(PL_W), .READ_NUM_W(RN_W), .DROP_BUBBLE(0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(up_if.valid), .in_ready(in_ready_b), .in_status(up_if.status),
        .in_read_num(up_if.read_num), .in_payload(up_if.payload),
        .out_valid(b_out.valid), .out_ready(b_out.ready), .out_status(b_out.status),
        .out_read_num(b_out.read_num), .out_payload(b_out.payload),
        .occupancy(occ_b), .bubble_drops(drops_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] st, input logic [8:0] rn,
                         input logic [15:0] pl);
        up_if.valid    = v;
        up_if.status   = st;
        up_if.read_num = rn;
        up_if.payload  = pl;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        flush       = 1'b0;
        a_out.ready = 1'b1;
        drive(1'b0, BUBBLE, 9'd0, 16'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int   idx;
        int   nout;
        int   na;
        int   nb;
        logic acc;

        // ---- Reset state ----
        rst = 1'b1;
        flush = 1'b0;
        a_out.ready = 1'b1;
        drive(1'b0, BUBBLE, 9'd0, 16'd0);
        tick();
        chk("rst_in_ready_low", 32'(up_if.ready), 32'd0);
        tick();
        chk("rst_out_valid", 32'(a_out.valid), 32'd0);
        chk("rst_out_status", 32'(a_out.status), 32'd0);
        chk("rst_out_read_num", 32'(a_out.read_num), 32'd0);
        chk("rst_out_payload", 32'(a_out.payload), 32'd0);
        chk("rst_occupancy", 32'(occ_a), 32'd0);
        chk("rst_bubble_drops", 32'(drops_a), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready_after", 32'(up_if.ready), 32'd1);

        // ---- Latency DEPTH=2: accepted at edge n, visible after edge n+2 ----
        drive(1'b1, BCK_RUN, 9'd5, 16'h00A5);
        tick();
        drive(1'b0, BUBBLE, 9'd0, 16'd0);
        chk("lat_n0_valid", 32'(a_out.valid), 32'd0);
        chk("lat_n0_occ", 32'(occ_a), 32'd1);
        tick();
        chk("lat_n1_valid", 32'(a_out.valid), 32'd0);
        tick();
        chk("lat_n2_valid", 32'(a_out.valid), 32'd1);
        chk("lat_n2_status", 32'(a_out.status), 32'(BCK_RUN));
        chk("lat_n2_read_num", 32'(a_out.read_num), 32'd5);
        chk("lat_n2_payload", 32'(a_out.payload), 32'h00A5);
        tick();
        chk("lat_n3_valid", 32'(a_out.valid), 32'd0);
        chk("lat_n3_occ", 32'(occ_a), 32'd0);

        // ---- Backpressure DEPTH=3: 8 tokens, out_ready low for edges 3..9 ----
        do_reset();
        idx = 0;
        nout = 0;
        for (int c = 0; c < 24; c++) begin
            a_out.ready = !(c >= 3 && c <= 9);
            if (idx < 8) drive(1'b1, BCK_RUN, 9'(16 + idx), 16'(16'h0100 + idx));
            else         drive(1'b0, BUBBLE, 9'd0, 16'd0);
            acc = up_if.valid && in_ready_b;
            if (b_out.valid && b_out.ready) begin
                if (nout < 8) chk("bp_order", 32'(b_out.read_num), 32'(16 + nout));
                nout++;
            end
            tick();
            if (acc) idx++;
            if (c == 4) begin
                chk("bp_full_occ", 32'(occ_b), 32'd5);
                chk("bp_full_in_ready", 32'(in_ready_b), 32'd0);
            end
            if (c == 10) begin
                chk("bp_release_occ", 32'(occ_b), 32'd4);
                chk("bp_release_in_ready", 32'(in_ready_b), 32'd1);
            end
            if (c == 17) chk("bp_out_count_e17", 32'(nout), 32'd8);
        end
        chk("bp_accepted", 32'(idx), 32'd8);
        chk("bp_out_count_final", 32'(nout), 32'd8);
        chk("bp_occ_final", 32'(occ_b), 32'd0);

        // ---- Bubble drop: BCK_INI, 0, 0, BCK_RUN ----
        do_reset();
        na = 0;
        nb = 0;
        for (int c = 0; c < 14; c++) begin
            case (c)
                0:       drive(1'b1, BCK_INI, 9'd1, 16'h0011);
                1:       drive(1'b1, BUBBLE,  9'd2, 16'h0022);
                2:       drive(1'b1, BUBBLE,  9'd3, 16'h0033);
                3:       drive(1'b1, BCK_RUN, 9'd4, 16'h0044);
                default: drive(1'b0, BUBBLE,  9'd0, 16'd0);
            endcase
            if (a_out.valid) begin
                if (na == 0)      chk("drop_a_first", 32'(a_out.read_num), 32'd1);
                else if (na == 1) chk("drop_a_second", 32'(a_out.read_num), 32'd4);
                na++;
            end
            if (b_out.valid) begin
                if (nb < 4) chk("drop_b_order", 32'(b_out.read_num), 32'(nb + 1));
                nb++;
            end
            tick();
        end
        chk("drop_a_outputs", 32'(na), 32'd2);
        chk("drop_a_count", 32'(drops_a), 32'd2);
        chk("drop_b_outputs", 32'(nb), 32'd4);
        chk("drop_b_count", 32'(drops_b), 32'd0);

        // ---- Flush at occupancy 4 (DEPTH=2) ----
        do_reset();
        a_out.ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, F_RUN, 9'(32 + c), 16'(16'h0200 + c));
            tick();
        end
        chk("flush_pre_occ", 32'(occ_a), 32'd4);
        chk("flush_pre_in_ready", 32'(up_if.ready), 32'd0);
        drive(1'b1, BCK_RUN, 9'h02F, 16'h02FF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, BUBBLE, 9'd0, 16'd0);
        #1;
        chk("flush_occ", 32'(occ_a), 32'd0);
        chk("flush_out_valid", 32'(a_out.valid), 32'd0);
        chk("flush_in_ready", 32'(up_if.ready), 32'd1);
        a_out.ready = 1'b1;
        na = 0;
        for (int c = 0; c < 6; c++) begin
            if (a_out.valid) na++;
            tick();
        end
        chk("flush_no_output", 32'(na), 32'd0);

        // ---- Reset mid-operation with 3 tokens held ----
        do_reset();
        a_out.ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, BCK_END, 9'(48 + c), 16'(16'h0300 + c));
            tick();
        end
        chk("mid_pre_occ", 32'(occ_a), 32'd3);
        rst = 1'b1;
        drive(1'b1, BCK_END, 9'h03F, 16'h03FF);
        #1;
        chk("mid_rst_in_ready", 32'(up_if.ready), 32'd0);
        tick();
        chk("mid_rst_out_valid", 32'(a_out.valid), 32'd0);
        chk("mid_rst_out_status", 32'(a_out.status), 32'd0);
        chk("mid_rst_out_read_num", 32'(a_out.read_num), 32'd0);
        chk("mid_rst_out_payload", 32'(a_out.payload), 32'd0);
        chk("mid_rst_occ", 32'(occ_a), 32'd0);
        rst = 1'b0;
        a_out.ready = 1'b1;
        drive(1'b1, F_RUN, 9'h033, 16'h1234);
        #1;
        chk("mid_post_in_ready", 32'(up_if.ready), 32'd1);
        tick();
        drive(1'b0, BUBBLE, 9'd0, 16'd0);
        chk("mid_lat_n0", 32'(a_out.valid), 32'd0);
        tick();
        chk("mid_lat_n1", 32'(a_out.valid), 32'd0);
        tick();
        chk("mid_lat_n2", 32'(a_out.valid), 32'd1);
        chk("mid_lat_read_num", 32'(a_out.read_num), 32'h033);
        chk("mid_lat_payload", 32'(a_out.payload), 32'h1234);
        chk("mid_lat_status", 32'(a_out.status), 32'(F_RUN));

        // ---- Saturation: 65520 drops, then 300 more ----
        do_reset();
        drive(1'b1, BUBBLE, 9'd7, 16'd0);
        for (int i = 0; i < 65520; i++) tick();
        chk("sat_preset", 32'(drops_a), 32'hFFF0);
        for (int i = 0; i < 300; i++) tick();
        drive(1'b0, BUBBLE, 9'd0, 16'd0);
        chk("sat_hold", 32'(drops_a), 32'hFFFF);
        chk("sat_occ", 32'(occ_a), 32'd0);
        chk("sat_no_drop_b", 32'(drops_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
